// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the multicycle processor control sequencer:
// opcode values, state encoding, latched op-class encoding and the ALU add code.
package proc_ctrl_pkg;

   localparam logic [4:0] OP_ALU  = 5'b00000;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_SW   = 5'b00111;
   localparam logic [4:0] OP_LW   = 5'b01000;

   localparam logic [4:0] ALU_ADD = 5'b00000;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
   } ctrl_state_t;

   typedef enum logic [1:0] {
      CLS_ALU  = 2'd0,
      CLS_ADDI = 2'd1,
      CLS_SW   = 2'd2,
      CLS_LW   = 2'd3
   } op_class_t;

endpackage

// File: rtl/ctrl_opcode_class.sv
// Combinational opcode classifier: one-hot flags for the four legal
// instruction classes plus an illegal flag for every other encoding.
module ctrl_opcode_class
   import proc_ctrl_pkg::*;
#(
   parameter int OPCODE_W = 5
) (
   input  logic [OPCODE_W-1:0] i_opcode,
   output logic                o_is_alu,
   output logic                o_is_addi,
   output logic                o_is_sw,
   output logic                o_is_lw,
   output logic                o_is_illegal
);

   assign o_is_alu     = (i_opcode == OPCODE_W'(OP_ALU));
   assign o_is_addi    = (i_opcode == OPCODE_W'(OP_ADDI));
   assign o_is_sw      = (i_opcode == OPCODE_W'(OP_SW));
   assign o_is_lw      = (i_opcode == OPCODE_W'(OP_LW));
   assign o_is_illegal = ~(o_is_alu | o_is_addi | o_is_sw | o_is_lw);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle processor control sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> WB.
// Holds the state register, latched op class and ALU-op field; datapath strobes
// are decoded combinationally from state, op class and the memory ready inputs.
// Optional feature macro CTRL_MEM_TIMEOUT_EN adds a data-memory wait counter that
// abandons the access after WAIT_MAX cycles without dmem_ready.
module multicycle_ctrl_fsm
   import proc_ctrl_pkg::*;
#(
   parameter int OPCODE_W = 5,
   parameter int ALUOP_W  = 5,
   parameter int WAIT_MAX = 15
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [ALUOP_W-1:0]  alu_op_in,
   input  logic                imem_ready,
   input  logic                dmem_ready,
   output logic                imem_req,
   output logic                ir_we,
   output logic                pc_we,
   output logic                alu_bsel,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic                rf_we,
   output logic                rf_wsel,
   output logic                retire,
   output logic                illegal,
   output logic                mem_timeout,
   output logic [2:0]          state
);

   ctrl_state_t          r_state;
   op_class_t            r_op_q;
   logic [ALUOP_W-1:0]   r_aluop_q;
   op_class_t            w_class;
   logic                 w_is_alu;
   logic                 w_is_addi;
   logic                 w_is_sw;
   logic                 w_is_lw;
   logic                 w_is_illegal;
   logic                 w_mem_timeout;

`ifdef CTRL_MEM_TIMEOUT_EN
   logic [7:0]           r_wait_cnt;
   assign w_mem_timeout = (r_wait_cnt == 8'(WAIT_MAX)) && !dmem_ready;
`else
   logic                 w_unused_wait_max;
   assign w_unused_wait_max = ^8'(WAIT_MAX);
   assign w_mem_timeout     = 1'b0;
`endif

   ctrl_opcode_class #(
      .OPCODE_W (OPCODE_W)
   ) u_class (
      .i_opcode     (opcode),
      .o_is_alu     (w_is_alu),
      .o_is_addi    (w_is_addi),
      .o_is_sw      (w_is_sw),
      .o_is_lw      (w_is_lw),
      .o_is_illegal (w_is_illegal)
   );

   // Collapse classifier flags into the compact op class latched in DECODE.
   always_comb begin
      w_class = CLS_ALU;
      if (w_is_addi)     w_class = CLS_ADDI;
      else if (w_is_sw)  w_class = CLS_SW;
      else if (w_is_lw)  w_class = CLS_LW;
      else if (w_is_alu) w_class = CLS_ALU;
   end

   // State sequencing plus the DECODE-time latches and the optional wait counter.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state    <= ST_FETCH;
         r_op_q     <= CLS_ALU;
         r_aluop_q  <= '0;
`ifdef CTRL_MEM_TIMEOUT_EN
         r_wait_cnt <= '0;
`endif
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (imem_ready) r_state <= ST_DECODE;
            end
            ST_DECODE: begin
               r_op_q    <= w_class;
               r_aluop_q <= alu_op_in;
               r_state   <= w_is_illegal ? ST_FETCH : ST_EXEC;
            end
            ST_EXEC: begin
`ifdef CTRL_MEM_TIMEOUT_EN
               r_wait_cnt <= '0;
`endif
               if (r_op_q == CLS_SW || r_op_q == CLS_LW) r_state <= ST_MEM;
               else                                      r_state <= ST_WB;
            end
            ST_MEM: begin
               if (dmem_ready) begin
                  r_state <= (r_op_q == CLS_SW) ? ST_FETCH : ST_WB;
               end else if (w_mem_timeout) begin
                  r_state <= ST_FETCH;
               end else begin
`ifdef CTRL_MEM_TIMEOUT_EN
                  r_wait_cnt <= r_wait_cnt + 8'd1;
`endif
               end
            end
            ST_WB: begin
               r_state <= ST_FETCH;
            end
            default: begin
               r_state <= ST_FETCH;
            end
         endcase
      end
   end

   // Strobe decode; everything except the state view is held low while in reset.
   always_comb begin
      imem_req    = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      alu_bsel    = 1'b0;
      alu_op      = '0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      rf_we       = 1'b0;
      rf_wsel     = 1'b0;
      retire      = 1'b0;
      illegal     = 1'b0;
      mem_timeout = 1'b0;
      if (reset_n) begin
         case (r_state)
            ST_FETCH: begin
               imem_req = 1'b1;
               ir_we    = imem_ready;
               pc_we    = imem_ready;
            end
            ST_DECODE: begin
               illegal = w_is_illegal;
            end
            ST_EXEC: begin
               alu_op   = (r_op_q == CLS_ALU) ? r_aluop_q : ALUOP_W'(ALU_ADD);
               alu_bsel = (r_op_q != CLS_ALU);
            end
            ST_MEM: begin
               alu_op      = (r_op_q == CLS_ALU) ? r_aluop_q : ALUOP_W'(ALU_ADD);
               alu_bsel    = (r_op_q != CLS_ALU);
               dmem_req    = 1'b1;
               dmem_we     = (r_op_q == CLS_SW);
               retire      = dmem_ready && (r_op_q == CLS_SW);
               mem_timeout = w_mem_timeout;
            end
            ST_WB: begin
               rf_we   = 1'b1;
               rf_wsel = (r_op_q == CLS_LW);
               retire  = 1'b1;
            end
            default: begin
               imem_req = 1'b0;
            end
         endcase
      end
   end

   assign state = r_state;

endmodule
